// File: rtl/sticky_pkg.sv
// sticky_pkg: shared GRS type, widths and pipeline-cut helpers for sticky_shifter_pipe.
//   grs_t      packed {g, r, s} guard/round/sticky triple
//   GRS_W      number of GRS bits appended below the shifted data
//   stage_cut  index of the log stage a pipeline register follows (-1 = before stage 0)
//   has_reg    1 when the node entering stage `node` (node == SHIFT_WIDTH: output) is registered
package sticky_pkg;
  localparam int GRS_W = 3;
  typedef struct packed {
    logic g;
    logic r;
    logic s;
  } grs_t;
  function automatic int stage_cut(int i, int sw, int rs);
    return (i + 1) * sw / (rs + 1) - 1;
  endfunction
  function automatic bit has_reg(int node, int sw, int rs);
    bit hit = 1'b0;
    for (int i = 0; i < rs; i++) hit |= (stage_cut(i, sw, rs) == node - 1);
    return hit;
  endfunction
endpackage

// File: rtl/sticky_shifter_pipe_if.sv
// sticky_shifter_pipe_if: valid/ready input and output channels of the sticky shifter.
//   in_valid/in_ready, in_a, in_b, in_arith, in_user   upstream beat
//   out_valid/out_ready, out_c {data, G, R, S}, out_user   downstream beat
//   master = producer/consumer side, slave = shifter side
interface sticky_shifter_pipe_if
  import sticky_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int USER_WIDTH  = 1
);
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       in_a;
  logic [SHIFT_WIDTH-1:0]      in_b;
  logic                        in_arith;
  logic [USER_WIDTH-1:0]       in_user;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH+GRS_W-1:0] out_c;
  logic [USER_WIDTH-1:0]       out_user;
  modport master (
    output in_valid, in_a, in_b, in_arith, in_user, out_ready,
    input  in_ready, out_valid, out_c, out_user
  );
  modport slave (
    input  in_valid, in_a, in_b, in_arith, in_user, out_ready,
    output in_ready, out_valid, out_c, out_user
  );
endinterface

// File: rtl/sticky_shift_stage.sv
// sticky_shift_stage: one combinational log stage; shifts {data, G, R} right by SHIFT_BY with fill
// and folds every ejected bit into the sticky bit.
//   en_i    shift enable (the matching bit of b)
//   fill_i  bit shifted in from the left
//   w_i/w_o {data, G, R} before/after the stage
//   s_i/s_o sticky before/after the stage
module sticky_shift_stage #(
  parameter int WIDTH    = 18,
  parameter int SHIFT_BY = 1
) (
  input  logic             en_i,
  input  logic             fill_i,
  input  logic             s_i,
  input  logic [WIDTH-1:0] w_i,
  output logic [WIDTH-1:0] w_o,
  output logic             s_o
);
  // shifts wider than the word eject everything and leave pure fill
  localparam int SH = SHIFT_BY < WIDTH ? SHIFT_BY : WIDTH;
  localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} >> SH;
  localparam logic [WIDTH-1:0] EJ = ~({WIDTH{1'b1}} << SH);
  assign w_o = en_i ? ((w_i >> SH) | ({WIDTH{fill_i}} & ~KEEP)) : w_i;
  assign s_o = s_i | (en_i & |(w_i & EJ));
endmodule

// File: rtl/sticky_shifter_pipe.sv
// sticky_shifter_pipe: pipelined right shifter returning shifted data plus exact G/R/S bits.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of sticky_shifter_pipe_if (in_* beat in, out_* beat out)
// Node j is the value entering log stage j (node SHIFT_WIDTH is the output); registered nodes
// form the pipeline slots, each with its own valid and a load-when-empty-or-draining rule.
module sticky_shifter_pipe
  import sticky_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int REG_STAGES  = 2,
  parameter int USER_WIDTH  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sticky_shifter_pipe_if.slave bus
);
  localparam int W = DATA_WIDTH + 2;
  typedef struct packed {
    logic                   v;
    logic [W-1:0]           w;
    logic                   s;
    logic [SHIFT_WIDTH-1:0] b;
    logic                   f;
    logic [USER_WIDTH-1:0]  u;
  } beat_t;
  for (genvar j = 0; j <= SHIFT_WIDTH; j++) begin : g_node
    localparam bit CUT = has_reg(j, SHIFT_WIDTH, REG_STAGES);
    beat_t node_d;
    beat_t node;
    logic  rdy_up;
    logic  rdy_dn;
    if (j == 0) begin : g_in
      assign node_d = '{v: bus.in_valid, w: {bus.in_a, 2'b00}, s: 1'b0, b: bus.in_b,
                        f: bus.in_arith & bus.in_a[DATA_WIDTH-1], u: bus.in_user};
    end else begin : g_chain
      assign node_d = g_node[j-1].g_st.stg;
    end
    if (CUT) begin : g_reg
      beat_t slot_q;
      logic  ld;
      assign ld = !slot_q.v | rdy_dn;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) slot_q <= '0;
        else if (ld) slot_q <= node_d;
      assign node   = slot_q;
      assign rdy_up = ld;
    end else begin : g_thru
      assign node   = node_d;
      assign rdy_up = rdy_dn;
    end
    if (j == SHIFT_WIDTH) begin : g_out
      grs_t grs;
      logic unused_ok;
      assign rdy_dn        = bus.out_ready;
      assign grs           = '{g: node.w[1], r: node.w[0], s: node.s};
      assign bus.out_valid = node.v;
      assign bus.out_c     = {node.w[W-1:2], grs};
      assign bus.out_user  = node.u;
      assign unused_ok     = ^{node.b, node.f};
    end else begin : g_st
      beat_t        stg;
      logic [W-1:0] w;
      logic         s;
      assign rdy_dn = g_node[j+1].rdy_up;
      sticky_shift_stage #(.WIDTH(W), .SHIFT_BY(2 ** j)) u_stage (
        .en_i  (node.b[j]),
        .fill_i(node.f),
        .s_i   (node.s),
        .w_i   (node.w),
        .w_o   (w),
        .s_o   (s)
      );
      assign stg = '{v: node.v, w: w, s: s, b: node.b, f: node.f, u: node.u};
    end
  end
  assign bus.in_ready = g_node[0].rdy_up;
endmodule

// File: tb/tb_sticky_shifter_pipe.sv
// tb_sticky_shifter_pipe: directed and random checks of sticky_shifter_pipe against a bit-level model.
module tb_sticky_shifter_pipe;
  localparam int N = 16, SW = 5, UW = 4;
  typedef struct {
    logic [N+2:0]  c;
    logic [UW-1:0] u;
    int            t;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int   checks = 0, fails = 0, cyc = 0;
  exp_t q2[$], q0[$], q5[$];
  bit   tog_en = 1'b0;
  logic [3:0] pat = 4'b1001;
  int   pi = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sticky_shifter_pipe_if #(.DATA_WIDTH(N), .SHIFT_WIDTH(SW), .USER_WIDTH(UW)) b2 ();
  sticky_shifter_pipe_if #(.DATA_WIDTH(N), .SHIFT_WIDTH(SW), .USER_WIDTH(UW)) b0 ();
  sticky_shifter_pipe_if #(.DATA_WIDTH(N), .SHIFT_WIDTH(SW), .USER_WIDTH(UW)) b5 ();
  sticky_shifter_pipe #(.DATA_WIDTH(N), .SHIFT_WIDTH(SW), .REG_STAGES(2), .USER_WIDTH(UW))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  sticky_shifter_pipe #(.DATA_WIDTH(N), .SHIFT_WIDTH(SW), .REG_STAGES(0), .USER_WIDTH(UW))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  sticky_shifter_pipe #(.DATA_WIDTH(N), .SHIFT_WIDTH(SW), .REG_STAGES(SW), .USER_WIDTH(UW))
    dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

  // A[idx] of the infinitely extended operand
  function automatic logic abit(logic [N-1:0] a, logic fill, int idx);
    return idx < 0 ? 1'b0 : idx >= N ? fill : a[idx];
  endfunction
  function automatic logic [N+2:0] model(logic [N-1:0] a, logic [SW-1:0] b, logic arith);
    logic fill = arith & a[N-1];
    int sh = int'(b);
    logic [N+2:0] c = '0;
    for (int i = 0; i < N; i++) c[i+3] = abit(a, fill, i + sh);
    c[2] = abit(a, fill, sh - 1);
    c[1] = abit(a, fill, sh - 2);
    for (int i = 0; i <= sh - 3; i++) c[0] = c[0] | abit(a, fill, i);
    return c;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (b2.in_valid && b2.in_ready) q2.push_back('{model(b2.in_a, b2.in_b, b2.in_arith), b2.in_user, cyc});
    if (b2.out_valid) begin
      if (q2.size() == 0) begin checks++; fails++; $display("FAIL dut2 out_valid with nothing in flight"); end
      else begin
        chk("dut2 out_c", 64'(b2.out_c), 64'(q2[0].c));
        chk("dut2 out_user", 64'(b2.out_user), 64'(q2[0].u));
        if (b2.out_ready) void'(q2.pop_front());
      end
    end
  end
  always @(negedge clk) if (rst_n) begin
    if (b0.in_valid && b0.in_ready) q0.push_back('{model(b0.in_a, b0.in_b, b0.in_arith), b0.in_user, cyc});
    if (b0.out_valid) begin
      if (q0.size() == 0) begin checks++; fails++; $display("FAIL dut0 out_valid with nothing in flight"); end
      else begin
        chk("dut0 out_c", 64'(b0.out_c), 64'(q0[0].c));
        chk("dut0 out_user", 64'(b0.out_user), 64'(q0[0].u));
        if (b0.out_ready) begin chk("dut0 latency", 64'(cyc - q0[0].t), 0); void'(q0.pop_front()); end
      end
    end
  end
  always @(negedge clk) if (rst_n) begin
    if (b5.in_valid && b5.in_ready) q5.push_back('{model(b5.in_a, b5.in_b, b5.in_arith), b5.in_user, cyc});
    if (b5.out_valid) begin
      if (q5.size() == 0) begin checks++; fails++; $display("FAIL dut5 out_valid with nothing in flight"); end
      else begin
        chk("dut5 out_c", 64'(b5.out_c), 64'(q5[0].c));
        chk("dut5 out_user", 64'(b5.out_user), 64'(q5[0].u));
        if (b5.out_ready) begin chk("dut5 latency", 64'(cyc - q5[0].t), SW); void'(q5.pop_front()); end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (tog_en) begin b2.out_ready = pat[pi]; pi = (pi + 1) % 4; end
  end

  task automatic push2(input logic [N-1:0] a, input logic [SW-1:0] b, input logic ar,
                       input logic [UW-1:0] u, output int t0);
    bit done = 1'b0;
    t0 = -1;
    b2.in_valid = 1'b1; b2.in_a = a; b2.in_b = b; b2.in_arith = ar; b2.in_user = u;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk); done = b2.in_ready; t0 = cyc;
      @(posedge clk); #1;
    end
    chk("dut2 beat accepted", 64'(done), 1);
  endtask
  task automatic one2(input logic [N-1:0] a, input logic [SW-1:0] b, input logic ar,
                      input logic [UW-1:0] u, input logic [N+2:0] exp);
    int t0;
    bit got = 1'b0;
    push2(a, b, ar, u, t0);
    b2.in_valid = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = b2.out_valid; end
    chk("dut2 latency", got ? 64'(cyc - t0) : 64'hFFFF, 2);
    chk("dut2 literal out_c", 64'(b2.out_c), 64'(exp));
    chk("dut2 literal out_user", 64'(b2.out_user), 64'(u));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [N-1:0]  va [8] = '{16'h1234, 16'hFFFF, 16'h8001, 16'h0000, 16'h7FFF, 16'hA5A5, 16'h0001, 16'hC000};
    logic [SW-1:0] vb [8] = '{5'd3, 5'd31, 5'd17, 5'd5, 5'd18, 5'd8, 5'd19, 5'd1};
    logic          vr [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int t0;
    bit empty;
    b2.in_valid = 0; b2.in_a = 0; b2.in_b = 0; b2.in_arith = 0; b2.in_user = 0; b2.out_ready = 1;
    b0.in_valid = 0; b0.in_a = 0; b0.in_b = 0; b0.in_arith = 0; b0.in_user = 0; b0.out_ready = 1;
    b5.in_valid = 0; b5.in_a = 0; b5.in_b = 0; b5.in_arith = 0; b5.in_user = 0; b5.out_ready = 1;
    chk("model B001>>4", 64'(model(16'hB001, 5'd4, 1'b0)), 64'h05801);
    chk("model 8000>>20 arith", 64'(model(16'h8000, 5'd20, 1'b1)), 64'h7FFFF);
    chk("model 8000>>20 logic", 64'(model(16'h8000, 5'd20, 1'b0)), 64'h00001);
    chk("model 0003>>1", 64'(model(16'h0003, 5'd1, 1'b0)), 64'h0000C);
    #1;
    chk("reset out_valid", 64'(b2.out_valid), 0);
    chk("reset out_c", 64'(b2.out_c), 0);
    chk("reset out_user", 64'(b2.out_user), 0);
    chk("reset dut5 out_c", 64'(b5.out_c), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; b2.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("in_ready after release", 64'(b2.in_ready), 1);
    b2.out_ready = 1'b1;
    one2(16'hB001, 5'd4, 1'b0, 4'h1, 19'h05801);
    one2(16'h8000, 5'd20, 1'b1, 4'h2, 19'h7FFFF);
    one2(16'h8000, 5'd20, 1'b0, 4'h3, 19'h00001);
    one2(16'h0003, 5'd0, 1'b0, 4'h4, 19'h00018);
    one2(16'h0003, 5'd1, 1'b0, 4'h5, 19'h0000C);
    one2(16'h0003, 5'd2, 1'b0, 4'h6, 19'h00006);
    tog_en = 1'b1;
    for (int i = 0; i < 8; i++) push2(va[i], vb[i], vr[i], 4'(i + 8), t0);
    b2.in_valid = 1'b0;
    for (int k = 0; k < 100 && q2.size() != 0; k++) @(posedge clk);
    tog_en = 1'b0;
    #1 b2.out_ready = 1'b0;
    push2(16'h1111, 5'd1, 1'b0, 4'hA, t0);
    push2(16'h2222, 5'd2, 1'b0, 4'hB, t0);
    b2.in_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mid-flight reset out_valid", 64'(b2.out_valid), 0);
    chk("mid-flight reset out_c", 64'(b2.out_c), 0);
    q2.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after mid-flight reset", 64'(b2.in_ready), 1);
    chk("out_valid after mid-flight reset", 64'(b2.out_valid), 0);
    b2.out_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      logic v = $urandom_range(0, 9) != 0;
      logic [N-1:0] a = N'($urandom);
      logic [SW-1:0] b = SW'($urandom);
      logic ar = 1'($urandom);
      logic [UW-1:0] u = UW'($urandom);
      b0.in_valid = v; b0.in_a = a; b0.in_b = b; b0.in_arith = ar; b0.in_user = u;
      b5.in_valid = v; b5.in_a = a; b5.in_b = b; b5.in_arith = ar; b5.in_user = u;
      @(posedge clk); #1;
    end
    b0.in_valid = 1'b0; b5.in_valid = 1'b0;
    repeat (SW + 3) @(posedge clk);
    empty = q2.size() == 0 && q0.size() == 0 && q5.size() == 0;
    chk("all scoreboards drained", 64'(empty), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
